// File: rtl/multiword_add_ctrl.sv
// Multi-word add controller: streams NUM_WORDS operand words, LS word first, through one shared ripple-carry adder.
// Optional build macro MULTIWORD_ADD_SUB_EN adds a 'sub' port for two's-complement subtraction.

module adder_nbit #(
   parameter int unsigned BIT_WIDTH = 4
) (
   input  logic [BIT_WIDTH-1:0] a,
   input  logic [BIT_WIDTH-1:0] b,
   input  logic                 cin,
   output logic [BIT_WIDTH-1:0] sum,
   output logic                 cout
);

   logic carry;

   always_comb begin
      carry = cin;
      sum   = '0;
      for (int unsigned i = 0; i < BIT_WIDTH; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
   end

endmodule

module multiword_add_ctrl #(
   parameter int unsigned BIT_WIDTH = 4,
   parameter int unsigned NUM_WORDS = 4
) (
   input  logic                 clk,
   input  logic                 n_rst,
`ifdef MULTIWORD_ADD_SUB_EN
   input  logic                 sub,
`endif
   input  logic                 start,
   input  logic                 carry_in,
   input  logic                 word_valid,
   input  logic [BIT_WIDTH-1:0] a_word,
   input  logic [BIT_WIDTH-1:0] b_word,
   output logic                 word_ready,
   output logic [BIT_WIDTH-1:0] sum_word,
   output logic                 sum_valid,
   output logic                 busy,
   output logic                 done,
   output logic                 carry_out
);

   localparam int unsigned CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   state_e               state_q, state_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 carry_q, carry_d;
   logic [BIT_WIDTH-1:0] sum_word_q, sum_word_d;
   logic                 sum_valid_q, sum_valid_d;
   logic                 carry_out_q, carry_out_d;

   logic [BIT_WIDTH-1:0] b_eff;
   logic                 init_carry;
   logic [BIT_WIDTH-1:0] add_sum;
   logic                 add_cout;
   logic                 last_word;

`ifdef MULTIWORD_ADD_SUB_EN
   logic sub_q, sub_d;

   // Subtraction is A + ~B + 1, so the initial carry is forced high.
   assign b_eff      = sub_q ? ~b_word : b_word;
   assign init_carry = sub | carry_in;

   always_comb begin
      sub_d = sub_q;
      if (state_q == IDLE && start) begin
         sub_d = sub;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         sub_q <= 1'b0;
      end else begin
         sub_q <= sub_d;
      end
   end
`else
   assign b_eff      = b_word;
   assign init_carry = carry_in;
`endif

   adder_nbit #(
      .BIT_WIDTH(BIT_WIDTH)
   ) u_adder (
      .a   (a_word),
      .b   (b_eff),
      .cin (carry_q),
      .sum (add_sum),
      .cout(add_cout)
   );

   assign last_word = (count_q == CW'(NUM_WORDS - 1));

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      carry_d     = carry_q;
      sum_word_d  = sum_word_q;
      sum_valid_d = 1'b0;
      carry_out_d = carry_out_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = RUN;
               count_d     = '0;
               carry_d     = init_carry;
               carry_out_d = 1'b0;
            end
         end
         RUN: begin
            if (word_valid) begin
               sum_word_d  = add_sum;
               sum_valid_d = 1'b1;
               carry_d     = add_cout;
               if (last_word) begin
                  state_d     = DONE;
                  carry_out_d = add_cout;
               end else begin
                  count_d = count_q + CW'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         carry_q     <= 1'b0;
         sum_word_q  <= '0;
         sum_valid_q <= 1'b0;
         carry_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         carry_q     <= carry_d;
         sum_word_q  <= sum_word_d;
         sum_valid_q <= sum_valid_d;
         carry_out_q <= carry_out_d;
      end
   end

   // Outputs are qualified by n_rst so they read zero during the reset cycle itself, not only after it.
   assign word_ready = n_rst && (state_q == RUN);
   assign busy       = n_rst && (state_q != IDLE);
   assign done       = n_rst && (state_q == DONE);
   assign sum_valid  = n_rst && sum_valid_q;
   assign sum_word   = n_rst ? sum_word_q : '0;
   assign carry_out  = n_rst && carry_out_q;

endmodule

// File: doc/multiword_add_ctrl.md
MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 4: word width of the shared ripple-carry adder.
REQ-002 SHALL have parameter NUM_WORDS, default 4, legal range 2..16: words per operand, least-significant word first.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port n_rst  input  1: reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1: begin a new multi-word operation; sampled only in IDLE.
REQ-006 SHALL have port carry_in  input  1: initial carry, latched when start is accepted.
REQ-007 SHALL have port word_valid  input  1: a_word/b_word hold a valid operand word.
REQ-008 SHALL have port a_word  input  BIT_WIDTH: operand A word.
REQ-009 SHALL have port b_word  input  BIT_WIDTH: operand B word.
REQ-010 SHALL have port word_ready  output  1: controller accepts a word this cycle.
REQ-011 SHALL have port sum_word  output  BIT_WIDTH: registered sum word.
REQ-012 SHALL have port sum_valid  output  1: sum_word is valid for exactly this cycle.
REQ-013 SHALL have port busy  output  1: high in every state except IDLE.
REQ-014 SHALL have port done  output  1: one-cycle pulse at operation end.
REQ-015 SHALL have port carry_out  output  1: final carry, held from done until the next accepted start.

Function
REQ-016 SHALL instantiate one adder_nbit of width BIT_WIDTH and SHALL use it for every word; no other adder logic.
REQ-017 SHALL implement states IDLE, RUN, DONE; IDLE->RUN when start=1; RUN->DONE on acceptance of word NUM_WORDS; DONE->IDLE unconditionally after one cycle.
REQ-018 SHALL drive word_ready=1 only in RUN; a word is accepted when word_valid=1 and word_ready=1.
REQ-019 SHALL feed the adder's carry input with the latched carry_in for word 0 and with the registered adder carry from the previous accepted word for later words.
REQ-020 SHALL register the adder sum into sum_word and assert sum_valid in the cycle after each acceptance (latency 1).
REQ-021 SHALL hold the running carry and word count unchanged in RUN cycles with word_valid=0 (gaps of any length allowed).
REQ-022 SHALL count accepted words with a counter of ceil(log2(NUM_WORDS)) bits that is cleared on start acceptance and never wraps within one operation.
REQ-023 SHALL assert done=1 in DONE, coincident with sum_valid for the last word, and update carry_out with the last word's adder carry in that same cycle.
REQ-024 SHALL ignore start outside IDLE and ignore word_valid outside RUN.
REQ-025 SHALL hold sum_word at its last value when sum_valid=0.

Reset
REQ-026 SHALL, in any cycle with n_rst=0, return to IDLE and drive busy=0, done=0, sum_valid=0, word_ready=0, sum_word=0, carry_out=0, with count and running carry cleared.
REQ-027 SHALL abandon a partially complete operation on reset mid-RUN or mid-DONE, producing no further sum_valid or done.

Configuration
REQ-028 SHALL, when MULTIWORD_ADD_SUB_EN is defined, add input port sub (1 bit), latched at start acceptance; with sub=1 each b_word is inverted before the adder and the initial carry is forced to 1 regardless of carry_in; carry_out=1 means no borrow.
REQ-029 SHALL, when MULTIWORD_ADD_SUB_EN is undefined, omit port sub and perform addition only.

Verification (BIT_WIDTH=4, NUM_WORDS=2)
REQ-030 SHALL check: start, carry_in=0; words (a,b)=(0xF,0x1),(0x3,0x0) back-to-back -> sum_word 0x0 then 0x4, done with carry_out=0.
REQ-031 SHALL check: words (0xF,0x1),(0xF,0x0), carry_in=0 -> sums 0x0,0x0, done with carry_out=1.
REQ-032 SHALL check: same stimulus as REQ-030 with 3 idle cycles between words -> identical sums and carry_out, word_ready high throughout the gap.
REQ-033 SHALL check: start pulsed in RUN and word_valid pulsed in IDLE -> no state change, no sum_valid.
REQ-034 SHALL check: n_rst=0 for one cycle after the first word is accepted -> IDLE next cycle, all outputs 0, no done.
REQ-035 SHALL check, with MULTIWORD_ADD_SUB_EN defined: sub=1, words (0x5,0x3),(0x0,0x0) -> sums 0x2,0x0, carry_out=1.
